// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALU/shift operations, result select,
// multiply/divide operation codes and the muldiv sequencer states.
package execute_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_NOR   = 3'd5;
    localparam logic [2:0] ALU_SLT   = 3'd6;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam logic [1:0] RESSEL_ALU   = 2'd0;
    localparam logic [1:0] RESSEL_SHIFT = 2'd1;
    localparam logic [1:0] RESSEL_HI    = 2'd2;
    localparam logic [1:0] RESSEL_LO    = 2'd3;

    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MD_MULT = 3'd1;
    localparam logic [2:0] MD_DIV  = 3'd2;
    localparam logic [2:0] MD_MTHI = 3'd3;
    localparam logic [2:0] MD_MTLO = 3'd4;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Multi-cycle operations are the ones that occupy the iterative unit.
    function automatic logic is_md_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU; overflow is reported only for signed add/subtract.
module alu
    import execute_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    input  logic         unsig,
    output logic [W-1:0] y,
    output logic         ov
);

    logic [W-1:0] sum_s;
    logic [W-1:0] diff_s;
    logic         lt_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;
    assign lt_s   = unsig ? (a < b) : ($signed(a) < $signed(b));

    // Operation select and signed overflow detection.
    always_comb begin
        y  = {W{1'b0}};
        ov = 1'b0;
        case (op)
            ALU_ADD: begin
                y  = sum_s;
                ov = !unsig && (a[W-1] == b[W-1]) && (sum_s[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                y  = diff_s;
                ov = !unsig && (a[W-1] != b[W-1]) && (diff_s[W-1] != a[W-1]);
            end
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOR:   y = ~(a | b);
            ALU_SLT:   y = {{(W-1){1'b0}}, lt_s};
            ALU_PASSB: y = b;
            default:   y = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
// Operates on magnitudes and fixes signs when leaving DONE.
module ex_muldiv
    import execute_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         op_div,
    input  logic         unsig,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic         mthi,
    input  logic         mtlo,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         stall
);

    md_state_e      state_r, state_s;
    logic [SHW-1:0] cnt_r;
    logic [2*W-1:0] acc_r;
    logic [W-1:0]   mcand_r, hi_r, lo_r;
    logic           div_r, negq_r, negr_r, divz_r;

    logic           a_neg_s, b_neg_s;
    logic [W-1:0]   a_mag_s, b_mag_s;
    logic [W:0]     mul_sum_s, div_trial_s;
    logic [2*W-1:0] mul_next_s, div_next_s, prod_s;
    logic [W-1:0]   res_hi_s, res_lo_s;

    assign a_neg_s = !unsig && opa[W-1];
    assign b_neg_s = !unsig && opb[W-1];
    assign a_mag_s = a_neg_s ? (~opa + {{(W-1){1'b0}}, 1'b1}) : opa;
    assign b_mag_s = b_neg_s ? (~opb + {{(W-1){1'b0}}, 1'b1}) : opb;

    // acc_r holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    assign mul_next_s  = {mul_sum_s, acc_r[W-1:1]};
    assign div_trial_s = acc_r[2*W-1:W-1] - {1'b0, mcand_r};
    assign div_next_s  = div_trial_s[W] ? {acc_r[2*W-2:0], 1'b0}
                                        : {div_trial_s[W-1:0], acc_r[W-2:0], 1'b1};
    assign prod_s      = negq_r ? (~acc_r + {{(2*W-1){1'b0}}, 1'b1}) : acc_r;

    // Sign fix-up of the finished result, with the divide-by-zero override.
    always_comb begin
        res_hi_s = prod_s[2*W-1:W];
        res_lo_s = prod_s[W-1:0];
        if (div_r) begin
            res_hi_s = negr_r ? (~acc_r[2*W-1:W] + {{(W-1){1'b0}}, 1'b1}) : acc_r[2*W-1:W];
            if (divz_r) begin
                res_lo_s = {W{1'b1}};
            end else begin
                res_lo_s = negq_r ? (~acc_r[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : acc_r[W-1:0];
            end
        end else begin
            res_hi_s = prod_s[2*W-1:W];
            res_lo_s = prod_s[W-1:0];
        end
    end

    // Next-state logic and stall request.
    always_comb begin
        state_s = state_r;
        stall   = 1'b0;
        case (state_r)
            MD_IDLE: begin
                stall   = start;
                state_s = start ? MD_BUSY : MD_IDLE;
            end
            MD_BUSY: begin
                stall   = 1'b1;
                state_s = (cnt_r == {SHW{1'b0}}) ? MD_DONE : MD_BUSY;
            end
            MD_DONE: state_s = MD_IDLE;
            default: state_s = MD_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= MD_IDLE;
        else        state_r <= state_s;
    end

    // Operand latch and one iteration step per BUSY cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r   <= {SHW{1'b0}};
            acc_r   <= {(2*W){1'b0}};
            mcand_r <= {W{1'b0}};
            div_r   <= 1'b0;
            negq_r  <= 1'b0;
            negr_r  <= 1'b0;
            divz_r  <= 1'b0;
        end else if (state_r == MD_IDLE && start) begin
            cnt_r   <= SHW'(W-1);
            acc_r   <= {{W{1'b0}}, (op_div ? a_mag_s : b_mag_s)};
            mcand_r <= op_div ? b_mag_s : a_mag_s;
            div_r   <= op_div;
            negq_r  <= a_neg_s ^ b_neg_s;
            negr_r  <= a_neg_s;
            divz_r  <= op_div && (opb == {W{1'b0}});
        end else if (state_r == MD_BUSY) begin
            acc_r <= div_r ? div_next_s : mul_next_s;
            if (cnt_r != {SHW{1'b0}}) cnt_r <= cnt_r - {{(SHW-1){1'b0}}, 1'b1};
        end
    end

    // Architectural HI/LO: muldiv completion or MTHI/MTLO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_r <= {W{1'b0}};
            lo_r <= {W{1'b0}};
        end else if (state_r == MD_DONE) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else begin
            if (mthi) hi_r <= opa;
            if (mtlo) lo_r <= opa;
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = (state_r != MD_IDLE);

endmodule

// File: rtl/shifter.sv
// Barrel shifter: logical left/right, arithmetic right and rotate right.
module shifter
    import execute_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic [W-1:0]   din,
    input  logic [SHW-1:0] amt,
    input  logic [1:0]     op,
    output logic [W-1:0]   y
);

    // Left shift by (W - amt) mod W completes the rotate; amt==0 folds to din.
    logic [SHW-1:0] neg_amt_s;
    assign neg_amt_s = {SHW{1'b0}} - amt;

    // Shift operation select.
    always_comb begin
        y = {W{1'b0}};
        case (op)
            SH_SLL:  y = din << amt;
            SH_SRL:  y = din >> amt;
            SH_SRA:  y = $signed(din) >>> amt;
            SH_ROR:  y = (din >> amt) | (din << neg_amt_s);
            default: y = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/execute_stage_md.sv
// Pipeline execute stage: ALU/shifter datapath, HI/LO muldiv unit, registered
// EX/MEM interface with stall-driven bubbles and overflow-gated writeback.
module execute_stage_md
    import execute_pkg::*;
#(
    parameter int W          = 32,
    parameter int SHW        = $clog2(W),
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_ex_valid,
    input  logic [W-1:0]          id_ex_rega,
    input  logic [W-1:0]          id_ex_regb,
    input  logic [W-1:0]          id_ex_imedext,
    input  logic                  id_ex_selimregb,
    input  logic [2:0]            id_ex_aluop,
    input  logic                  id_ex_unsig,
    input  logic [1:0]            id_ex_shiftop,
    input  logic [SHW-1:0]        id_ex_shiftamt,
    input  logic [1:0]            id_ex_resultsel,
    input  logic [2:0]            id_ex_mdop,
    input  logic                  id_ex_readmem,
    input  logic                  id_ex_writemem,
    input  logic                  id_ex_selwsource,
    input  logic [REG_ADDR_W-1:0] id_ex_regdest,
    input  logic                  id_ex_writereg,
    input  logic                  id_ex_writeov,
    output logic                  ex_stall,
    output logic                  ex_mem_valid,
    output logic                  ex_mem_readmem,
    output logic                  ex_mem_writemem,
    output logic                  ex_mem_selwsource,
    output logic [W-1:0]          ex_mem_regb,
    output logic [REG_ADDR_W-1:0] ex_mem_regdest,
    output logic                  ex_mem_writereg,
    output logic [W-1:0]          ex_mem_wbvalue,
    output logic                  ex_mem_ovf,
    output logic                  md_busy
);

    logic [W-1:0] alu_b_s, alu_y_s, sh_y_s, md_hi_s, md_lo_s, wb_s;
    logic         alu_ov_s, md_long_s, writereg_s, ovf_s;

    assign alu_b_s   = id_ex_selimregb ? id_ex_imedext : id_ex_regb;
    assign md_long_s = is_md_long(id_ex_mdop);

    alu #(.W(W)) u_alu (
        .a     (id_ex_rega),
        .b     (alu_b_s),
        .op    (id_ex_aluop),
        .unsig (id_ex_unsig),
        .y     (alu_y_s),
        .ov    (alu_ov_s)
    );

    shifter #(.W(W), .SHW(SHW)) u_shifter (
        .din (id_ex_regb),
        .amt (id_ex_shiftamt),
        .op  (id_ex_shiftop),
        .y   (sh_y_s)
    );

    ex_muldiv #(.W(W), .SHW(SHW)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .start  (id_ex_valid && md_long_s),
        .op_div (id_ex_mdop == MD_DIV),
        .unsig  (id_ex_unsig),
        .opa    (id_ex_rega),
        .opb    (id_ex_regb),
        .mthi   (id_ex_valid && (id_ex_mdop == MD_MTHI)),
        .mtlo   (id_ex_valid && (id_ex_mdop == MD_MTLO)),
        .hi     (md_hi_s),
        .lo     (md_lo_s),
        .busy   (md_busy),
        .stall  (ex_stall)
    );

    // Writeback value select; overflow only matters for ALU-selected results.
    always_comb begin
        wb_s = alu_y_s;
        case (id_ex_resultsel)
            RESSEL_ALU:   wb_s = alu_y_s;
            RESSEL_SHIFT: wb_s = sh_y_s;
            RESSEL_HI:    wb_s = md_hi_s;
            RESSEL_LO:    wb_s = md_lo_s;
            default:      wb_s = alu_y_s;
        endcase
        ovf_s = alu_ov_s && (id_ex_resultsel == RESSEL_ALU);
        if (md_long_s) begin
            writereg_s = 1'b0;
        end else begin
            writereg_s = id_ex_writereg && (!ovf_s || id_ex_writeov);
        end
    end

    // EX/MEM pipeline register; stalls and invalid slots become bubbles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_readmem    <= 1'b0;
            ex_mem_writemem   <= 1'b0;
            ex_mem_selwsource <= 1'b0;
            ex_mem_regb       <= {W{1'b0}};
            ex_mem_regdest    <= {REG_ADDR_W{1'b0}};
            ex_mem_writereg   <= 1'b0;
            ex_mem_wbvalue    <= {W{1'b0}};
            ex_mem_ovf        <= 1'b0;
        end else if (ex_stall || !id_ex_valid) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_readmem    <= 1'b0;
            ex_mem_writemem   <= 1'b0;
            ex_mem_selwsource <= 1'b0;
            ex_mem_regb       <= {W{1'b0}};
            ex_mem_regdest    <= {REG_ADDR_W{1'b0}};
            ex_mem_writereg   <= 1'b0;
            ex_mem_wbvalue    <= {W{1'b0}};
            ex_mem_ovf        <= 1'b0;
        end else begin
            ex_mem_valid      <= 1'b1;
            ex_mem_readmem    <= id_ex_readmem;
            ex_mem_writemem   <= id_ex_writemem;
            ex_mem_selwsource <= id_ex_selwsource;
            ex_mem_regb       <= id_ex_regb;
            ex_mem_regdest    <= id_ex_regdest;
            ex_mem_writereg   <= writereg_s;
            ex_mem_wbvalue    <= wb_s;
            ex_mem_ovf        <= ovf_s;
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// Self-checking bench for execute_stage_md: directed corner cases plus random
// ALU/shift and muldiv traffic against a plain-arithmetic reference model.
module tb_execute_stage_md;
    import execute_pkg::*;

    localparam int W = 32;
    localparam int SHW = 5;
    localparam int RW = 5;
    localparam int MD_STALL = W + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_ex_valid, id_ex_selimregb, id_ex_unsig;
    logic [W-1:0]  id_ex_rega, id_ex_regb, id_ex_imedext;
    logic [2:0]    id_ex_aluop, id_ex_mdop;
    logic [1:0]    id_ex_shiftop, id_ex_resultsel;
    logic [SHW-1:0] id_ex_shiftamt;
    logic          id_ex_readmem, id_ex_writemem, id_ex_selwsource;
    logic [RW-1:0] id_ex_regdest;
    logic          id_ex_writereg, id_ex_writeov;
    logic          ex_stall, ex_mem_valid, ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource;
    logic [W-1:0]  ex_mem_regb, ex_mem_wbvalue;
    logic [RW-1:0] ex_mem_regdest;
    logic          ex_mem_writereg, ex_mem_ovf, md_busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    execute_stage_md #(.W(W), .SHW(SHW), .REG_ADDR_W(RW)) dut (
        .clock(clock), .reset(reset), .id_ex_valid(id_ex_valid),
        .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imedext(id_ex_imedext),
        .id_ex_selimregb(id_ex_selimregb), .id_ex_aluop(id_ex_aluop), .id_ex_unsig(id_ex_unsig),
        .id_ex_shiftop(id_ex_shiftop), .id_ex_shiftamt(id_ex_shiftamt),
        .id_ex_resultsel(id_ex_resultsel), .id_ex_mdop(id_ex_mdop),
        .id_ex_readmem(id_ex_readmem), .id_ex_writemem(id_ex_writemem),
        .id_ex_selwsource(id_ex_selwsource), .id_ex_regdest(id_ex_regdest),
        .id_ex_writereg(id_ex_writereg), .id_ex_writeov(id_ex_writeov),
        .ex_stall(ex_stall), .ex_mem_valid(ex_mem_valid), .ex_mem_readmem(ex_mem_readmem),
        .ex_mem_writemem(ex_mem_writemem), .ex_mem_selwsource(ex_mem_selwsource),
        .ex_mem_regb(ex_mem_regb), .ex_mem_regdest(ex_mem_regdest),
        .ex_mem_writereg(ex_mem_writereg), .ex_mem_wbvalue(ex_mem_wbvalue),
        .ex_mem_ovf(ex_mem_ovf), .md_busy(md_busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_nop();
        id_ex_valid = 1'b0; id_ex_rega = '0; id_ex_regb = '0; id_ex_imedext = '0;
        id_ex_selimregb = 1'b0; id_ex_aluop = ALU_ADD; id_ex_unsig = 1'b0;
        id_ex_shiftop = SH_SLL; id_ex_shiftamt = '0; id_ex_resultsel = RESSEL_ALU;
        id_ex_mdop = MD_NONE; id_ex_readmem = 1'b0; id_ex_writemem = 1'b0;
        id_ex_selwsource = 1'b0; id_ex_regdest = '0; id_ex_writereg = 1'b0; id_ex_writeov = 1'b0;
    endtask

    function automatic void model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic uns, output logic [31:0] y, output logic ov);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        ov = 1'b0;
        y = 32'h0;
        case (op)
            ALU_ADD: begin y = a + b; r = sa + sb; ov = !uns && (r > 64'sd2147483647 || r < -64'sd2147483648); end
            ALU_SUB: begin y = a - b; r = sa - sb; ov = !uns && (r > 64'sd2147483647 || r < -64'sd2147483648); end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOR: y = ~(a | b);
            ALU_SLT: y = (uns ? (a < b) : (sa < sb)) ? 32'd1 : 32'd0;
            default: y = b;
        endcase
    endfunction

    function automatic logic [31:0] model_shift(input logic [1:0] op, input logic [31:0] x, input int amt);
        case (op)
            SH_SLL:  return x << amt;
            SH_SRL:  return x >> amt;
            SH_SRA:  return $signed(x) >>> amt;
            default: return (amt == 0) ? x : ((x >> amt) | (x << (32 - amt)));
        endcase
    endfunction

    function automatic void model_md(input logic dv, input logic uns, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint sa, sb;
        int ia, ib;
        if (!dv) begin
            sa = $signed(a);
            sb = $signed(b);
            p = uns ? ({32'h0, a} * {32'h0, b}) : 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'h0) begin
            lo = 32'hFFFFFFFF; hi = a;
        end else if (uns) begin
            lo = a / b; hi = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            lo = 32'h80000000; hi = 32'h0;
        end else begin
            ia = a; ib = b;
            lo = ia / ib; hi = ia % ib;
        end
    endfunction

    // Issues MULT/DIV, counts stall cycles (bounded), then reads LO and HI back via MFLO/MFHI.
    task automatic run_md(input logic dv, input logic uns, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic retire_ok, output logic [31:0] lo, output logic [31:0] hi);
        set_nop();
        id_ex_valid = 1'b1; id_ex_rega = a; id_ex_regb = b; id_ex_unsig = uns;
        id_ex_mdop = dv ? MD_DIV : MD_MULT; id_ex_regdest = 5'd3; id_ex_writereg = 1'b1;
        #1;
        stalls = 0;
        while (ex_stall && stalls < 100) begin
            stalls++;
            tick();
        end
        tick();
        retire_ok = (ex_mem_valid === 1'b1) && (ex_mem_writereg === 1'b0) && (md_busy === 1'b0);
        set_nop();
        id_ex_valid = 1'b1; id_ex_resultsel = RESSEL_LO; id_ex_writereg = 1'b1;
        tick();
        lo = ex_mem_wbvalue;
        id_ex_resultsel = RESSEL_HI;
        tick();
        hi = ex_mem_wbvalue;
        set_nop();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_nop();
        #2;
        n_checks++;
        if ({ex_mem_valid, ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg,
             ex_mem_ovf, md_busy, ex_stall} !== 8'h00 || ex_mem_wbvalue !== 32'h0 || ex_mem_regb !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b wb=%h busy=%b required all zero", ex_mem_valid, ex_mem_wbvalue, md_busy);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_alu_overflow();
        set_nop();
        id_ex_valid = 1'b1; id_ex_rega = 32'h7FFFFFFF; id_ex_regb = 32'h1; id_ex_aluop = ALU_ADD;
        id_ex_writereg = 1'b1; id_ex_writeov = 1'b0; id_ex_regdest = 5'd9;
        tick();
        n_checks++;
        if ({ex_mem_valid, ex_mem_ovf, ex_mem_writereg} !== 3'b110 || ex_mem_wbvalue !== 32'h80000000) begin
            n_fail++;
            $display("FAIL add_ovf_gated: got v/ovf/wr=%b%b%b wb=%h required 110 80000000", ex_mem_valid, ex_mem_ovf, ex_mem_writereg, ex_mem_wbvalue);
        end
        id_ex_writeov = 1'b1;
        tick();
        n_checks++;
        if ({ex_mem_ovf, ex_mem_writereg} !== 2'b11 || ex_mem_regdest !== 5'd9) begin
            n_fail++;
            $display("FAIL add_ovf_writeov: got ovf/wr=%b%b rd=%0d required 11 9", ex_mem_ovf, ex_mem_writereg, ex_mem_regdest);
        end
        id_ex_writeov = 1'b0; id_ex_resultsel = RESSEL_SHIFT;
        tick();
        n_checks++;
        if ({ex_mem_ovf, ex_mem_writereg} !== 2'b01 || ex_mem_wbvalue !== 32'h1) begin
            n_fail++;
            $display("FAIL ovf_ignored_shift: got ovf/wr=%b%b wb=%h required 01 1", ex_mem_ovf, ex_mem_writereg, ex_mem_wbvalue);
        end
        set_nop();
    endtask

    task automatic test_bubbles();
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            set_nop();
            id_ex_valid = pat[3-i]; id_ex_rega = 32'(i + 1); id_ex_regb = 32'd10;
            id_ex_writereg = 1'b1; id_ex_readmem = 1'b1; id_ex_writemem = 1'b1;
            tick();
            n_checks++;
            if ({ex_mem_valid, ex_mem_writereg, ex_mem_readmem, ex_mem_writemem} !== {4{pat[3-i]}}) begin
                n_fail++;
                $display("FAIL bubble_slot%0d: got v/wr/rd/wm=%b%b%b%b required all %b", i,
                         ex_mem_valid, ex_mem_writereg, ex_mem_readmem, ex_mem_writemem, pat[3-i]);
            end
        end
        set_nop();
    endtask

    task automatic test_muldiv_directed();
        logic [31:0] d_a [4];
        logic [31:0] d_b [4];
        logic [31:0] e_lo [4];
        logic [31:0] e_hi [4];
        logic [3:0]  d_div, d_uns;
        int stalls;
        logic ok;
        logic [31:0] lo, hi;
        d_a  = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000, 32'd5};
        d_b  = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
        e_lo = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        e_hi = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd5};
        d_div = 4'b0111;
        d_uns = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            run_md(d_div[3-i], d_uns[3-i], d_a[i], d_b[i], stalls, ok, lo, hi);
            model_lo = e_lo[i];
            model_hi = e_hi[i];
            n_checks++;
            if (stalls != MD_STALL || ok !== 1'b1) begin
                n_fail++;
                $display("FAIL md_dir%0d_timing: got stalls=%0d retire_ok=%b required %0d 1", i, stalls, ok, MD_STALL);
            end
            n_checks++;
            if (lo !== e_lo[i] || hi !== e_hi[i]) begin
                n_fail++;
                $display("FAIL md_dir%0d_result: got lo=%h hi=%h required lo=%h hi=%h", i, lo, hi, e_lo[i], e_hi[i]);
            end
        end
    endtask

    task automatic test_muldiv_random();
        logic dv, uns;
        logic [31:0] a, b, lo, hi, elo, ehi;
        int stalls;
        logic ok;
        for (int i = 0; i < 10; i++) begin
            dv = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            if (i == 9) begin a = $urandom; b = 32'h0; dv = 1'b1; uns = 1'b0; end
            model_md(dv, uns, a, b, ehi, elo);
            run_md(dv, uns, a, b, stalls, ok, lo, hi);
            model_lo = elo;
            model_hi = ehi;
            n_checks++;
            if (stalls != MD_STALL || ok !== 1'b1 || lo !== elo || hi !== ehi) begin
                n_fail++;
                $display("FAIL md_rand%0d: op=%0d uns=%b a=%h b=%h got lo=%h hi=%h stalls=%0d ok=%b required lo=%h hi=%h",
                         i, dv, uns, a, b, lo, hi, stalls, ok, elo, ehi);
            end
        end
    endtask

    task automatic test_mt();
        logic [31:0] v1, v2, v3;
        v1 = $urandom; v2 = $urandom; v3 = $urandom;
        set_nop();
        id_ex_valid = 1'b1; id_ex_mdop = MD_MTHI; id_ex_rega = v1;
        tick();
        id_ex_mdop = MD_MTLO; id_ex_rega = v2;
        tick();
        id_ex_mdop = MD_MTLO; id_ex_rega = v3; id_ex_resultsel = RESSEL_LO; id_ex_writereg = 1'b1;
        tick();
        n_checks++;
        if (ex_mem_wbvalue !== v2) begin
            n_fail++;
            $display("FAIL mflo_pre_edge: got %h required %h", ex_mem_wbvalue, v2);
        end
        id_ex_mdop = MD_NONE; id_ex_resultsel = RESSEL_HI;
        tick();
        n_checks++;
        if (ex_mem_wbvalue !== v1 || ex_mem_writereg !== 1'b1) begin
            n_fail++;
            $display("FAIL mfhi_after_mthi: got %h wr=%b required %h 1", ex_mem_wbvalue, ex_mem_writereg, v1);
        end
        id_ex_resultsel = RESSEL_LO;
        tick();
        n_checks++;
        if (ex_mem_wbvalue !== v3) begin
            n_fail++;
            $display("FAIL mflo_after_mtlo: got %h required %h", ex_mem_wbvalue, v3);
        end
        model_hi = v1;
        model_lo = v3;
        set_nop();
    endtask

    task automatic test_random_alu();
        logic [31:0] b_eff, y, ewb;
        logic ov, eovf, ewr;
        for (int i = 0; i < 60; i++) begin
            set_nop();
            id_ex_valid = ($urandom_range(0, 4) != 0);
            id_ex_rega = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFF0 + 32'($urandom_range(0, 31)) : $urandom;
            id_ex_regb = $urandom;
            id_ex_imedext = $urandom;
            id_ex_selimregb = 1'($urandom_range(0, 1));
            id_ex_aluop = 3'($urandom_range(0, 7));
            id_ex_unsig = 1'($urandom_range(0, 1));
            id_ex_shiftop = 2'($urandom_range(0, 3));
            id_ex_shiftamt = 5'($urandom_range(0, 31));
            id_ex_resultsel = 2'($urandom_range(0, 3));
            id_ex_readmem = 1'($urandom_range(0, 1));
            id_ex_writemem = 1'($urandom_range(0, 1));
            id_ex_selwsource = 1'($urandom_range(0, 1));
            id_ex_regdest = 5'($urandom_range(0, 31));
            id_ex_writereg = 1'($urandom_range(0, 1));
            id_ex_writeov = 1'($urandom_range(0, 1));
            b_eff = id_ex_selimregb ? id_ex_imedext : id_ex_regb;
            model_alu(id_ex_aluop, id_ex_rega, b_eff, id_ex_unsig, y, ov);
            case (id_ex_resultsel)
                RESSEL_ALU:   ewb = y;
                RESSEL_SHIFT: ewb = model_shift(id_ex_shiftop, id_ex_regb, int'(id_ex_shiftamt));
                RESSEL_HI:    ewb = model_hi;
                default:      ewb = model_lo;
            endcase
            eovf = ov && (id_ex_resultsel == RESSEL_ALU);
            ewr = id_ex_writereg && (!eovf || id_ex_writeov);
            tick();
            n_checks++;
            if (!id_ex_valid) begin
                if ({ex_mem_valid, ex_mem_writereg, ex_mem_readmem, ex_mem_writemem, ex_mem_ovf} !== 5'b0) begin
                    n_fail++;
                    $display("FAIL rand_bubble%0d: got v/wr/rd/wm/ovf=%b%b%b%b%b required 00000", i,
                             ex_mem_valid, ex_mem_writereg, ex_mem_readmem, ex_mem_writemem, ex_mem_ovf);
                end
            end else if (ex_mem_valid !== 1'b1 || ex_mem_wbvalue !== ewb || ex_mem_ovf !== eovf ||
                         ex_mem_writereg !== ewr || ex_mem_regdest !== id_ex_regdest || ex_mem_regb !== id_ex_regb ||
                         ex_mem_readmem !== id_ex_readmem || ex_mem_writemem !== id_ex_writemem ||
                         ex_mem_selwsource !== id_ex_selwsource) begin
                n_fail++;
                $display("FAIL rand_alu%0d: op=%0d sel=%0d got wb=%h ovf=%b wr=%b v=%b required wb=%h ovf=%b wr=%b", i,
                         id_ex_aluop, id_ex_resultsel, ex_mem_wbvalue, ex_mem_ovf, ex_mem_writereg, ex_mem_valid, ewb, eovf, ewr);
            end
        end
        set_nop();
    endtask

    task automatic test_reset_midrun();
        set_nop();
        id_ex_valid = 1'b1; id_ex_mdop = MD_MTLO; id_ex_rega = 32'hA5A50001;
        tick();
        id_ex_mdop = MD_NONE; id_ex_rega = 32'h11; id_ex_regb = 32'h22; id_ex_writereg = 1'b1; id_ex_readmem = 1'b1;
        tick();
        n_checks++;
        if (ex_mem_valid !== 1'b1 || ex_mem_wbvalue !== 32'h33) begin
            n_fail++;
            $display("FAIL pre_reset_add: got v=%b wb=%h required 1 33", ex_mem_valid, ex_mem_wbvalue);
        end
        #2;
        reset = 1'b0;
        set_nop();
        #1;
        n_checks++;
        if ({ex_mem_valid, ex_mem_writereg, ex_mem_readmem, md_busy} !== 4'b0 || ex_mem_wbvalue !== 32'h0 || ex_mem_regb !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_exmem: got v=%b wr=%b rd=%b wb=%h required all zero", ex_mem_valid, ex_mem_writereg, ex_mem_readmem, ex_mem_wbvalue);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        id_ex_valid = 1'b1; id_ex_mdop = MD_MULT; id_ex_rega = 32'd1234; id_ex_regb = 32'd5678;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (md_busy !== 1'b1 || ex_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL md_busy_midop: got busy=%b stall=%b required 1 1", md_busy, ex_stall);
        end
        #2;
        reset = 1'b0;
        set_nop();
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || ex_stall !== 1'b0 || ex_mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_md: got busy=%b stall=%b v=%b required 0 0 0", md_busy, ex_stall, ex_mem_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        model_hi = '0;
        model_lo = '0;
        id_ex_valid = 1'b1; id_ex_resultsel = RESSEL_LO; id_ex_writereg = 1'b1;
        tick();
        n_checks++;
        if (ex_mem_wbvalue !== 32'h0 || ex_mem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mflo_after_reset: got v=%b wb=%h required 1 0", ex_mem_valid, ex_mem_wbvalue);
        end
        id_ex_resultsel = RESSEL_HI;
        tick();
        n_checks++;
        if (ex_mem_wbvalue !== 32'h0) begin
            n_fail++;
            $display("FAIL mfhi_after_reset: got %h required 0", ex_mem_wbvalue);
        end
        set_nop();
    endtask

    initial begin
        test_reset();
        test_alu_overflow();
        test_bubbles();
        test_muldiv_directed();
        test_mt();
        test_random_alu();
        test_muldiv_random();
        test_random_alu();
        test_reset_midrun();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
